// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with flush and optional performance counters.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble counters; otherwise they read as 0.
module pipe_stage_reg #(
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Handshake: a beat moves on a port only in a cycle where valid and ready are
    // both high at the rising edge; valid never depends combinationally on ready,
    // and a valid beat's payload is held stable until it is taken.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_accept;
    logic              w_drain;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                w_main_nxt = '0;
                w_skid_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_accept && w_drain) begin
                        w_main_nxt  = in_data;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    // The state encoding doubles as the entry count, so occupancy is the FSM state.
    assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters saturate and deliberately ignore flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (!r_out_valid && (r_bubble_cnt != CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
